// File: rtl/lsu_pkg.sv
// Shared opcode/state encodings and access-size helpers for the load/store unit.
package lsu_pkg;

  localparam int MASK_W = 8;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LD   = 4'd4,
    OP_LBU  = 4'd5,
    OP_LHU  = 4'd6,
    OP_LWU  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Reserved encodings 12..15 collapse to a pass-through.
  function automatic lsu_op_e decode_op(input logic [3:0] raw);
    return (raw > 4'd11) ? OP_NONE : lsu_op_e'(raw);
  endfunction

  function automatic logic is_load(input lsu_op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(input lsu_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input lsu_op_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_LWU, OP_SW: return 2'd2;
      OP_LD, OP_SD:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [2:0] off);
    case (op_size(op))
      2'd1:    return off[0] != 1'b0;
      2'd2:    return off[1:0] != 2'b00;
      2'd3:    return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready data-memory bus between the LSU (master) and the memory (slave).
interface lsu_if #(
  parameter int XLEN  = 64,
  parameter int MEM_W = 64
);
  logic                       mem_req_valid_o;
  logic                       mem_req_ready_i;
  logic [XLEN-1:0]            mem_addr_o;
  logic                       mem_wen_o;
  logic [lsu_pkg::MASK_W-1:0] mem_wmask_o;
  logic [MEM_W-1:0]           mem_wdata_o;
  logic                       mem_rsp_valid_i;
  logic [MEM_W-1:0]           mem_rdata_i;

  modport master (
    output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wmask_o, mem_wdata_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wmask_o, mem_wdata_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, store strobe/shift, load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MEM_W = 64
) (
  input  lsu_op_e            op,
  input  logic [2:0]         off,
  input  logic [XLEN-1:0]    wdata,
  input  logic [MEM_W-1:0]   rdata,
  output logic               misalign,
  output logic [MASK_W-1:0]  wmask,
  output logic [MEM_W-1:0]   wdata_sh,
  output logic [XLEN-1:0]    rdata_ext
);

  logic [MEM_W-1:0] sh;

  always_comb begin
    misalign  = is_misaligned(op, off);
    sh        = rdata >> {off, 3'b000};
    wmask     = '0;
    wdata_sh  = '0;
    rdata_ext = '0;

    if (is_store(op)) begin
      wdata_sh = MEM_W'(wdata) << {off, 3'b000};
    end

    case (op)
      OP_SB: wmask = 8'h01 << off;
      OP_SH: wmask = 8'h03 << off;
      OP_SW: wmask = 8'h0F << off;
      OP_SD: wmask = 8'hFF;
      default: wmask = '0;
    endcase

    case (op)
      OP_LB:  rdata_ext = {{(XLEN-8){sh[7]}},   sh[7:0]};
      OP_LH:  rdata_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
      OP_LW:  rdata_ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
      OP_LBU: rdata_ext = {{(XLEN-8){1'b0}},    sh[7:0]};
      OP_LHU: rdata_ext = {{(XLEN-16){1'b0}},   sh[15:0]};
      OP_LWU: rdata_ext = {{(XLEN-32){1'b0}},   sh[31:0]};
      OP_LD:  rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on the data-memory bus, result handed to write-back.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MEM_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_lsu,
  output logic            ready_o_lsu,
  input  logic [3:0]      lsuop_i_lsu,
  input  logic [XLEN-1:0] addr_i_lsu,
  input  logic [XLEN-1:0] wdata_i_lsu,
  output logic            valid_o_lsu,
  input  logic            wb_ready_i_lsu,
  output logic [XLEN-1:0] result_o_lsu,
  output logic            misalign_o_lsu,
  lsu_if.master           mem
);

  lsu_state_e       state;
  lsu_op_e          op_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;

  lsu_op_e          op_in;
  lsu_op_e          op_sel;
  logic [2:0]       off_sel;
  logic [XLEN-1:0]  wdata_sel;
  logic             misalign;
  logic [MASK_W-1:0] wmask;
  logic [MEM_W-1:0] wdata_sh;
  logic [XLEN-1:0]  rdata_ext;

  assign op_in = decode_op(lsuop_i_lsu);

  // While idle the lane logic looks at the incoming instruction; afterwards at the latched one.
  always_comb begin
    op_sel    = op_q;
    off_sel   = addr_q[2:0];
    wdata_sel = wdata_q;
    if (state == S_IDLE) begin
      op_sel    = op_in;
      off_sel   = addr_i_lsu[2:0];
      wdata_sel = wdata_i_lsu;
    end
  end

  lsu_align #(
    .XLEN  (XLEN),
    .MEM_W (MEM_W)
  ) u_align (
    .op        (op_sel),
    .off       (off_sel),
    .wdata     (wdata_sel),
    .rdata     (mem.mem_rdata_i),
    .misalign  (misalign),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  assign mem.mem_addr_o = {addr_q[XLEN-1:3], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      op_q                <= OP_NONE;
      addr_q              <= '0;
      wdata_q             <= '0;
      ready_o_lsu         <= 1'b1;
      valid_o_lsu         <= 1'b0;
      result_o_lsu        <= '0;
      misalign_o_lsu      <= 1'b0;
      mem.mem_req_valid_o <= 1'b0;
      mem.mem_wen_o       <= 1'b0;
      mem.mem_wmask_o     <= '0;
      mem.mem_wdata_o     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i_lsu) begin
            op_q        <= op_in;
            addr_q      <= addr_i_lsu;
            wdata_q     <= wdata_i_lsu;
            ready_o_lsu <= 1'b0;
            if (op_in == OP_NONE) begin
              result_o_lsu   <= addr_i_lsu;
              misalign_o_lsu <= 1'b0;
              valid_o_lsu    <= 1'b1;
              state          <= S_RESP;
            end else if (misalign) begin
              // Faulting access: report straight away, never touch the bus.
              result_o_lsu   <= '0;
              misalign_o_lsu <= 1'b1;
              valid_o_lsu    <= 1'b1;
              state          <= S_RESP;
            end else begin
              misalign_o_lsu      <= 1'b0;
              mem.mem_req_valid_o <= 1'b1;
              mem.mem_wen_o       <= is_store(op_in);
              mem.mem_wmask_o     <= wmask;
              mem.mem_wdata_o     <= wdata_sh;
              state               <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready_i) begin
            mem.mem_req_valid_o <= 1'b0;
            state               <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rsp_valid_i) begin
            result_o_lsu <= is_load(op_q) ? rdata_ext : '0;
            valid_o_lsu  <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (wb_ready_i_lsu) begin
            valid_o_lsu <= 1'b0;
            ready_o_lsu <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected results queued at issue, popped when write-back sees them.
module tb_lsu;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i_lsu;
  logic            ready_o_lsu;
  logic [3:0]      lsuop_i_lsu;
  logic [XLEN-1:0] addr_i_lsu;
  logic [XLEN-1:0] wdata_i_lsu;
  logic            valid_o_lsu;
  logic            wb_ready_i_lsu;
  logic [XLEN-1:0] result_o_lsu;
  logic            misalign_o_lsu;

  always #5 clk = ~clk;

  lsu_if #(.XLEN(XLEN), .MEM_W(64)) mem ();

  lsu #(.XLEN(XLEN), .MEM_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i_lsu    (valid_i_lsu),
    .ready_o_lsu    (ready_o_lsu),
    .lsuop_i_lsu    (lsuop_i_lsu),
    .addr_i_lsu     (addr_i_lsu),
    .wdata_i_lsu    (wdata_i_lsu),
    .valid_o_lsu    (valid_o_lsu),
    .wb_ready_i_lsu (wb_ready_i_lsu),
    .result_o_lsu   (result_o_lsu),
    .misalign_o_lsu (misalign_o_lsu),
    .mem            (mem)
  );

  typedef struct {
    logic [63:0] result;
    logic        misalign;
    logic        req;
    logic [63:0] maddr;
    logic        wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%016h want 0x%016h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata);
    exp_t        e;
    int          off;
    int          sz;
    logic [63:0] v;
    e = '{result: 64'd0, misalign: 1'b0, req: 1'b0, maddr: 64'd0, wen: 1'b0,
          wmask: 8'd0, wdata: 64'd0};
    off = int'(addr[2:0]);
    if (op == 4'd0 || op > 4'd11) begin
      e.result = addr;
      return e;
    end
    case (op)
      4'd1, 4'd5, 4'd8:  sz = 1;
      4'd2, 4'd6, 4'd9:  sz = 2;
      4'd3, 4'd7, 4'd10: sz = 4;
      default:           sz = 8;
    endcase
    if (off % sz != 0) begin
      e.misalign = 1'b1;
      return e;
    end
    e.req   = 1'b1;
    e.maddr = addr & ~64'h7;
    if (op >= 4'd8) begin
      e.wen   = 1'b1;
      e.wmask = 8'((1 << sz) - 1) << off;
      e.wdata = wdata << (8 * off);
    end else begin
      v = rdata >> (8 * off);
      case (op)
        4'd1: e.result = {{56{v[7]}},  v[7:0]};
        4'd2: e.result = {{48{v[15]}}, v[15:0]};
        4'd3: e.result = {{32{v[31]}}, v[31:0]};
        4'd5: e.result = {56'd0, v[7:0]};
        4'd6: e.result = {48'd0, v[15:0]};
        4'd7: e.result = {32'd0, v[31:0]};
        default: e.result = rdata;
      endcase
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata,
                       input int req_dly, input int rsp_dly, input int wb_dly);
    exp_t e;
    exp_t got_e;
    e = model(op, addr, wdata, rdata);
    exp_q.push_back(e);

    chk({tag, ".rdy_idle"}, ready_o_lsu, 1'b1);
    valid_i_lsu = 1'b1;
    lsuop_i_lsu = op;
    addr_i_lsu  = addr;
    wdata_i_lsu = wdata;
    tick();
    valid_i_lsu = 1'b0;
    lsuop_i_lsu = 4'd0;
    addr_i_lsu  = {$urandom, $urandom};
    wdata_i_lsu = {$urandom, $urandom};
    chk({tag, ".rdy_busy"}, ready_o_lsu, 1'b0);
    chk({tag, ".req_valid"}, mem.mem_req_valid_o, e.req);

    if (e.req) begin
      for (int i = 0; i <= req_dly; i++) begin
        chk({tag, ".req_held"}, mem.mem_req_valid_o, 1'b1);
        chk({tag, ".addr"},  mem.mem_addr_o,  e.maddr);
        chk({tag, ".wen"},   mem.mem_wen_o,   e.wen);
        chk({tag, ".wmask"}, mem.mem_wmask_o, e.wmask);
        chk({tag, ".wdata"}, mem.mem_wdata_o, e.wdata);
        if (i < req_dly) begin
          // Stray response and a new instruction while the request is pending must both be ignored.
          mem.mem_rsp_valid_i = 1'b1;
          mem.mem_rdata_i     = ~rdata;
          valid_i_lsu         = 1'b1;
        end else begin
          mem.mem_req_ready_i = 1'b1;
        end
        tick();
        mem.mem_req_ready_i = 1'b0;
        mem.mem_rsp_valid_i = 1'b0;
        valid_i_lsu         = 1'b0;
        chk({tag, ".rdy_req"}, ready_o_lsu, 1'b0);
      end
      chk({tag, ".req_drop"}, mem.mem_req_valid_o, 1'b0);
      for (int i = 0; i < rsp_dly; i++) begin
        tick();
        chk({tag, ".vld_wait"}, valid_o_lsu, 1'b0);
        chk({tag, ".rdy_wait"}, ready_o_lsu, 1'b0);
      end
      mem.mem_rsp_valid_i = 1'b1;
      mem.mem_rdata_i     = rdata;
      tick();
      mem.mem_rsp_valid_i = 1'b0;
      mem.mem_rdata_i     = {$urandom, $urandom};
    end

    chk({tag, ".vld"}, valid_o_lsu, 1'b1);
    for (int i = 0; i < wb_dly; i++) begin
      tick();
      chk({tag, ".vld_hold"}, valid_o_lsu, 1'b1);
      chk({tag, ".rdy_resp"}, ready_o_lsu, 1'b0);
    end

    if (exp_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      got_e = exp_q.pop_front();
      chk({tag, ".result"},   result_o_lsu,   got_e.result);
      chk({tag, ".misalign"}, misalign_o_lsu, got_e.misalign);
    end

    wb_ready_i_lsu = 1'b1;
    tick();
    wb_ready_i_lsu = 1'b0;
    chk({tag, ".vld_done"}, valid_o_lsu, 1'b0);
    chk({tag, ".rdy_done"}, ready_o_lsu, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst                 = 1'b1;
    valid_i_lsu         = 1'b0;
    lsuop_i_lsu         = 4'd0;
    addr_i_lsu          = '0;
    wdata_i_lsu         = '0;
    wb_ready_i_lsu      = 1'b0;
    mem.mem_req_ready_i = 1'b0;
    mem.mem_rsp_valid_i = 1'b0;
    mem.mem_rdata_i     = '0;
    tick();
    tick();
    chk("rst.ready",     ready_o_lsu,         1'b1);
    chk("rst.valid",     valid_o_lsu,         1'b0);
    chk("rst.result",    result_o_lsu,        64'd0);
    chk("rst.misalign",  misalign_o_lsu,      1'b0);
    chk("rst.req_valid", mem.mem_req_valid_o, 1'b0);
    chk("rst.addr",      mem.mem_addr_o,      64'd0);
    chk("rst.wen",       mem.mem_wen_o,       1'b0);
    chk("rst.wmask",     mem.mem_wmask_o,     8'd0);
    chk("rst.wdata",     mem.mem_wdata_o,     64'd0);
    rst = 1'b0;
    tick();

    do_op("none",    4'd0,  64'h0000_0000_8000_0010, 64'd0,  64'd0, 0, 0, 0);
    do_op("lb",      4'd1,  64'h0000_0000_8000_0003, 64'd0,  64'h1122_3344_8566_7788, 0, 0, 0);
    do_op("lbu",     4'd5,  64'h0000_0000_8000_0003, 64'd0,  64'h1122_3344_8566_7788, 0, 0, 0);
    do_op("sh",      4'd9,  64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD, 64'h5555_5555_5555_5555, 0, 0, 0);
    do_op("lw_mis",  4'd3,  64'h0000_0000_8000_0002, 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    do_op("ld_stall",4'd4,  64'h0000_0000_8000_0008, 64'd0,  64'hDEAD_BEEF_CAFE_F00D, 3, 2, 2);
    do_op("lh",      4'd2,  64'h0000_0000_8000_0006, 64'd0,  64'hF00D_0000_0000_0000, 0, 1, 0);
    do_op("lhu",     4'd6,  64'h0000_0000_8000_0006, 64'd0,  64'hF00D_0000_0000_0000, 1, 0, 1);
    do_op("lw",      4'd3,  64'h0000_0000_8000_0004, 64'd0,  64'h8000_0001_1234_5678, 0, 0, 0);
    do_op("lwu",     4'd7,  64'h0000_0000_8000_0004, 64'd0,  64'h8000_0001_1234_5678, 0, 0, 0);
    do_op("lh_lo",   4'd2,  64'h0000_0000_8000_0002, 64'd0,  64'h0000_0000_7FFE_0000, 0, 0, 0);
    do_op("sb",      4'd8,  64'h0000_0000_8000_0105, 64'h1234_5678_9ABC_DEEE, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 0);
    do_op("sw",      4'd10, 64'h0000_0000_8000_0104, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 0, 0);
    do_op("sd",      4'd11, 64'h0000_0000_8000_0100, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1, 1);
    do_op("sd_mis",  4'd11, 64'h0000_0000_8000_0104, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0);
    do_op("sh_mis",  4'd9,  64'h0000_0000_8000_0001, 64'hBEEF, 64'h0, 0, 0, 1);
    do_op("ld_mis",  4'd4,  64'h0000_0000_8000_0007, 64'd0,  64'h0, 0, 0, 0);
    do_op("op14",    4'd14, 64'h0000_0000_0000_1234, 64'd0,  64'h0, 0, 0, 0);

    // Abort an LD while it waits for its response.
    valid_i_lsu = 1'b1;
    lsuop_i_lsu = 4'd4;
    addr_i_lsu  = 64'h0000_0000_8000_0000;
    tick();
    valid_i_lsu         = 1'b0;
    mem.mem_req_ready_i = 1'b1;
    tick();
    mem.mem_req_ready_i = 1'b0;
    chk("abort.in_wait", mem.mem_req_valid_o, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.ready",  ready_o_lsu,         1'b1);
    chk("abort.valid",  valid_o_lsu,         1'b0);
    chk("abort.result", result_o_lsu,        64'd0);
    chk("abort.req",    mem.mem_req_valid_o, 1'b0);
    mem.mem_rsp_valid_i = 1'b1;
    mem.mem_rdata_i     = 64'h1111_2222_3333_4444;
    tick();
    mem.mem_rsp_valid_i = 1'b0;
    chk("abort.late_rsp_valid", valid_o_lsu, 1'b0);
    chk("abort.late_rsp_ready", ready_o_lsu, 1'b1);
    tick();
    chk("abort.still_idle", valid_o_lsu, 1'b0);

    do_op("after_abort", 4'd0, 64'h0000_0000_CAFE_0000, 64'd0, 64'd0, 0, 0, 0);

    chk("sb.drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
